// File: rtl/sensor_frontend_if.sv
// Photodiode front-end signal bundle.
//   sensor         : raw asynchronous comparator input
//   arm            : single-cycle pulse opening a measurement window
//   sensor_out     : debounced light level (1 = lit)
//   sensor_trigger : single-cycle pulse on the first qualifying rising edge in a window
//   timeout        : single-cycle pulse when a window expires without a trigger
//   armed          : high while a window is open
//   edge_count     : saturating count of debounced rising edges
// master = stimulus side, slave = sensor_frontend.
interface sensor_frontend_if;
  logic        sensor;
  logic        arm;
  logic        sensor_out;
  logic        sensor_trigger;
  logic        timeout;
  logic        armed;
  logic [15:0] edge_count;

  modport master (
    output sensor, arm,
    input  sensor_out, sensor_trigger, timeout, armed, edge_count
  );

  modport slave (
    input  sensor, arm,
    output sensor_out, sensor_trigger, timeout, armed, edge_count
  );
endinterface

// File: rtl/sensor_frontend.sv
// Conditioning stage between the photodiode pin and the latency counter:
// synchronise + debounce the sensor, issue one trigger per arm window and
// flag a timeout when no qualifying light edge arrives.
// Ports:
//   clock : system clock
//   rstn  : asynchronous active-low reset
//   bus   : sensor_frontend_if.slave (sensor/arm in; sensor_out, sensor_trigger,
//           timeout, armed, edge_count out, all registered)
module sensor_frontend #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 27,
  parameter int unsigned TIMEOUT_CYCLES  = 13500000,
  parameter bit          ACTIVE_HIGH     = 1'b1
) (
  input  logic              clock,
  input  logic              rstn,
  sensor_frontend_if.slave  bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned EC_W = 16;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [EC_W-1:0] EC_MAX  = {EC_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DARK = 2'd1,
    ST_ARMED     = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   level_q, level_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   rise;
  logic [EC_W-1:0]        edge_cnt_q, edge_cnt_d;
  state_e                 state_q, state_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   trig_q, trig_d;
  logic                   timeout_q, timeout_d;
  logic                   armed_q;

  // Synchroniser chain; polarity fixed up after the last flop.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sensor};
  end

  assign s = sync_q[SYNC_STAGES-1] ^ ~ACTIVE_HIGH;

  // Debounce: a new level needs DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    rise     = 1'b0;
    if (s != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = s;
        rise    = s;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Saturating rising-edge counter.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (rise && (edge_cnt_q != EC_MAX)) edge_cnt_d = edge_cnt_q + EC_W'(1);
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      level_q    <= 1'b0;
      db_cnt_q   <= '0;
      edge_cnt_q <= '0;
    end else begin
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  // FSM state register plus registered window outputs.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      to_cnt_q  <= '0;
      trig_q    <= 1'b0;
      timeout_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      trig_q    <= trig_d;
      timeout_q <= timeout_d;
      armed_q   <= (state_q != ST_IDLE);
    end
  end

  // Next state: arm always (re)opens a window chosen from the current level.
  always_comb begin
    state_d = state_q;
    if (bus.arm) begin
      state_d = level_q ? ST_WAIT_DARK : ST_ARMED;
    end else begin
      case (state_q)
        ST_WAIT_DARK: begin
          if (to_cnt_q == TO_LAST) state_d = ST_IDLE;
          else if (!level_q)       state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (rise || (to_cnt_q == TO_LAST)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: arm beats rise, rise beats timeout expiry.
  always_comb begin
    trig_d    = 1'b0;
    timeout_d = 1'b0;
    to_cnt_d  = to_cnt_q;
    if (bus.arm) begin
      to_cnt_d = '0;
    end else if (state_q != ST_IDLE) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if ((state_q == ST_ARMED) && rise) trig_d    = 1'b1;
      else if (to_cnt_q == TO_LAST)      timeout_d = 1'b1;
    end
  end

  assign bus.sensor_out     = level_q;
  assign bus.sensor_trigger = trig_q;
  assign bus.timeout        = timeout_q;
  assign bus.armed          = armed_q;
  assign bus.edge_count     = edge_cnt_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// Self-checking bench for sensor_frontend: directed scenarios plus a
// randomized run against a window/sample-history reference model.
module tb_sensor_frontend;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DB   = 4;
  localparam int unsigned TO   = 100;
  localparam bit          AH   = 1'b1;

  logic clock;
  logic rstn;
  int   n_checks;
  int   n_fail;

  sensor_frontend_if bus   ();
  sensor_frontend_if bus_n ();

  sensor_frontend #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
                    .TIMEOUT_CYCLES(TO), .ACTIVE_HIGH(1'b1)) dut (
    .clock (clock),
    .rstn  (rstn),
    .bus   (bus)
  );

  sensor_frontend #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
                    .TIMEOUT_CYCLES(TO), .ACTIVE_HIGH(1'b0)) dut_n (
    .clock (clock),
    .rstn  (rstn),
    .bus   (bus_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model state: raw-sample delay line, last DB conditioned samples,
  // and the window described by open/need-dark/arm time.
  bit m_sq[$];
  bit m_win[$];
  bit m_level;
  int m_cnt;
  bit m_open;
  bit m_wait;
  int m_arm_cyc;
  int m_cyc;
  bit e_trig, e_to, e_armed;

  task automatic model_reset();
    m_sq.delete();
    m_win.delete();
    for (int i = 0; i < int'(SYNC); i++) m_sq.push_back(1'b0);
    for (int i = 0; i < int'(DB); i++)   m_win.push_back(1'b0);
    m_level = 1'b0; m_cnt = 0; m_open = 1'b0; m_wait = 1'b0;
    m_arm_cyc = 0; m_cyc = 0; e_trig = 1'b0; e_to = 1'b0; e_armed = 1'b0;
  endtask

  task automatic model_step(input bit sensor_v, input bit arm_v);
    bit s, lvl_pre, rise, all_diff;
    lvl_pre = m_level;
    s = m_sq.pop_front() ^ ~AH;
    m_sq.push_back(sensor_v);
    void'(m_win.pop_front());
    m_win.push_back(s);
    all_diff = 1'b1;
    foreach (m_win[i]) if (m_win[i] == m_level) all_diff = 1'b0;
    rise = 1'b0;
    if (all_diff) begin
      m_level = ~m_level;
      rise = m_level;
    end
    if (rise && m_cnt < 65535) m_cnt++;
    e_trig = 1'b0; e_to = 1'b0; e_armed = m_open;
    if (arm_v) begin
      m_open = 1'b1; m_wait = lvl_pre; m_arm_cyc = m_cyc;
    end else if (m_open) begin
      if (!m_wait && rise) begin e_trig = 1'b1; m_open = 1'b0; end
      else if (m_cyc - m_arm_cyc == int'(TO)) begin e_to = 1'b1; m_open = 1'b0; end
      else if (m_wait && !lvl_pre) m_wait = 1'b0;
    end
    m_cyc++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.arm = 1'b0; bus.sensor = 1'b0;
    bus_n.arm = 1'b0; bus_n.sensor = 1'b1;
    repeat (3) tick();
    rstn = 1'b1;
  endtask

  task automatic arm_pulse();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    rstn = 1'b0;
    bus.arm = 1'b0; bus.sensor = 1'b0;
    bus_n.arm = 1'b0; bus_n.sensor = 1'b1;
    repeat (2) tick();
    obs = {bus.sensor_out, bus.sensor_trigger, bus.timeout, bus.armed, bus.edge_count};
    n_checks++;
    if (obs !== 20'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 20'h0);
    end
    obs = {bus_n.sensor_out, bus_n.sensor_trigger, bus_n.timeout, bus_n.armed, bus_n.edge_count};
    n_checks++;
    if (obs !== 20'h0) begin
      n_fail++; $display("FAIL reset_outputs_inv: got %h expected %h", obs, 20'h0);
    end
    rstn = 1'b1;
  endtask

  task automatic test_latency();
    logic [2:0] obs, exp;
    do_reset();
    arm_pulse();
    repeat (10) tick();
    bus.sensor = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      obs = {bus.sensor_out, bus.sensor_trigger, bus.armed};
      exp = {k >= 6, k == 6, k <= 6};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL latency k=%0d: out/trig/armed got %b expected %b", k, obs, exp);
      end
    end
    n_checks++;
    if (bus.edge_count !== 16'd1) begin
      n_fail++; $display("FAIL latency_edge_count: got %0d expected 1", bus.edge_count);
    end
  endtask

  task automatic test_glitch();
    logic [2:0] obs, exp;
    do_reset();
    arm_pulse();
    for (int k = 1; k <= 101; k++) begin
      bus.sensor = ((k >= 1 && k <= 3) || (k >= 5 && k <= 7)) ? 1'b1 : 1'b0;
      tick();
      obs = {bus.sensor_out, bus.sensor_trigger, bus.timeout};
      exp = {1'b0, 1'b0, k == 100};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL glitch k=%0d: out/trig/timeout got %b expected %b", k, obs, exp);
      end
    end
    n_checks++;
    if ({bus.armed, bus.edge_count} !== 17'h0) begin
      n_fail++; $display("FAIL glitch_end: armed=%b edge_count=%0d expected 0/0", bus.armed, bus.edge_count);
    end
  endtask

  task automatic test_lit_at_arm();
    logic [2:0] obs, exp;
    do_reset();
    bus.sensor = 1'b1;
    repeat (6) tick();
    n_checks++;
    if ({bus.sensor_out, bus.edge_count} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL lit_pre: out=%b edge_count=%0d expected 1/1", bus.sensor_out, bus.edge_count);
    end
    arm_pulse();
    tick();
    n_checks++;
    if (bus.armed !== 1'b1) begin
      n_fail++; $display("FAIL lit_armed: got %b expected 1", bus.armed);
    end
    bus.sensor = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 9) bus.sensor = 1'b1;
      tick();
      obs = {bus.sensor_out, bus.sensor_trigger, bus.timeout};
      exp = {(k < 6) || (k >= 14), k == 14, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL lit_at_arm k=%0d: out/trig/timeout got %b expected %b", k, obs, exp);
      end
    end
    n_checks++;
    if (bus.edge_count !== 16'd2) begin
      n_fail++; $display("FAIL lit_edge_count: got %0d expected 2", bus.edge_count);
    end
  endtask

  task automatic test_rearm_priority();
    logic [2:0] obs, exp;
    // re-arm late in the window restarts the timeout
    do_reset();
    arm_pulse();
    for (int k = 1; k <= 191; k++) begin
      bus.arm = (k == 90);
      tick();
      obs = {1'b0, bus.sensor_trigger, bus.timeout};
      exp = {1'b0, 1'b0, k == 190};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL rearm k=%0d: trig/timeout got %b expected %b", k, obs[1:0], exp[1:0]);
      end
    end
    bus.arm = 1'b0;
    // arm coincident with rise suppresses the trigger
    do_reset();
    arm_pulse();
    repeat (3) tick();
    bus.sensor = 1'b1;
    for (int k = 1; k <= 107; k++) begin
      bus.arm = (k == 6);
      tick();
      obs = {bus.sensor_trigger, bus.timeout, bus.sensor_out};
      exp = {1'b0, k == 106, k >= 6};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL arm_vs_rise k=%0d: trig/timeout/out got %b expected %b", k, obs, exp);
      end
    end
    bus.arm = 1'b0;
    n_checks++;
    if (bus.edge_count !== 16'd1) begin
      n_fail++; $display("FAIL arm_vs_rise_count: got %0d expected 1", bus.edge_count);
    end
    // rise on the final timeout cycle wins
    do_reset();
    arm_pulse();
    for (int k = 1; k <= 102; k++) begin
      bus.sensor = (k >= 95);
      tick();
      obs = {1'b0, bus.sensor_trigger, bus.timeout};
      exp = {1'b0, k == 100, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL rise_vs_timeout k=%0d: trig/timeout got %b expected %b", k, obs[1:0], exp[1:0]);
      end
    end
    n_checks++;
    if (bus.armed !== 1'b0) begin
      n_fail++; $display("FAIL rise_vs_timeout_armed: got %b expected 0", bus.armed);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] obs;
    do_reset();
    bus.sensor = 1'b1;
    repeat (6) tick();
    arm_pulse();
    tick();
    n_checks++;
    if ({bus.armed, bus.sensor_out} !== 2'b11) begin
      n_fail++; $display("FAIL mid_pre: armed/out got %b expected 11", {bus.armed, bus.sensor_out});
    end
    bus.sensor = 1'b0;
    repeat (4) tick();
    #2 rstn = 1'b0;
    #1;
    obs = {bus.sensor_out, bus.sensor_trigger, bus.timeout, bus.armed, bus.edge_count};
    n_checks++;
    if (obs !== 20'h0) begin
      n_fail++; $display("FAIL mid_reset_async: got %h expected %h", obs, 20'h0);
    end
    tick();
    rstn = 1'b1;
    bus.sensor = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (bus.sensor_out !== (k == 6)) begin
        n_fail++; $display("FAIL mid_relatch k=%0d: got %b expected %b", k, bus.sensor_out, k == 6);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp;
    do_reset();
    tick();
    force dut.edge_cnt_q = 16'hFFFD;
    #1;
    release dut.edge_cnt_q;
    for (int p = 0; p < 3; p++) begin
      bus.sensor = 1'b1;
      repeat (7) tick();
      exp = (p == 0) ? 16'hFFFE : 16'hFFFF;
      n_checks++;
      if (bus.edge_count !== exp) begin
        n_fail++; $display("FAIL edge_sat p=%0d: got %h expected %h", p, bus.edge_count, exp);
      end
      bus.sensor = 1'b0;
      repeat (7) tick();
    end
  endtask

  task automatic test_active_low();
    do_reset();
    repeat (8) tick();
    n_checks++;
    if (bus_n.sensor_out !== 1'b0) begin
      n_fail++; $display("FAIL inv_dark: got %b expected 0", bus_n.sensor_out);
    end
    bus_n.sensor = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (bus_n.sensor_out !== (k == 6)) begin
        n_fail++; $display("FAIL inv_latency k=%0d: got %b expected %b", k, bus_n.sensor_out, k == 6);
      end
    end
    n_checks++;
    if (bus_n.edge_count !== 16'd1) begin
      n_fail++; $display("FAIL inv_edge_count: got %0d expected 1", bus_n.edge_count);
    end
  endtask

  task automatic test_random();
    logic [19:0] obs, exp;
    int run;
    bit sv, av;
    do_reset();
    model_reset();
    sv = 1'b0;
    run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        sv = ~sv;
        run = int'($urandom_range(1, 10));
      end
      run--;
      av = ($urandom_range(0, 49) == 0);
      bus.sensor = sv;
      bus.arm = av;
      model_step(sv, av);
      tick();
      obs = {bus.sensor_out, bus.sensor_trigger, bus.timeout, bus.armed, bus.edge_count};
      exp = {m_level, e_trig, e_to, e_armed, 16'(m_cnt)};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL random cyc=%0d: out/trig/to/armed/count got %h expected %h", i, obs, exp);
      end
      n_checks++;
      if ((bus.sensor_trigger & bus.timeout) !== 1'b0) begin
        n_fail++; $display("FAIL random_exclusive cyc=%0d: trig&timeout got 1 expected 0", i);
      end
    end
    bus.arm = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_lit_at_arm();
    test_rearm_priority();
    test_reset_mid();
    test_saturation();
    test_active_low();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_frontend.md
Name: sensor_frontend

Overview:
- Conditioning stage between the raw photodiode pin and the latency measurement counter, all in the 27 MHz `clock` domain.
- Synchronises and debounces the sensor input, then produces a filtered level for the LED.
- Issues exactly one trigger pulse per measurement window, where a window is opened by the arm pulse (the crossed frame start trigger).
- Flags a timeout when no qualifying light edge arrives.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on `sensor`; legal range 2..4.
- DEBOUNCE_CYCLES, 27: cycles a new input level must be stable before it is accepted; 1 us at 27 MHz; legal range ≥1.
- TIMEOUT_CYCLES, 13500000: cycles after arm with no trigger before `timeout` fires; 500 ms; legal range ≥2.
- ACTIVE_HIGH, 1: 1 = light reads as sensor=1; 0 = input is inverted after the synchroniser.

Ports:
- clock, in, 1: 27 MHz system clock.
- rstn, in, 1: asynchronous active-low reset.
- sensor, in, 1: raw asynchronous photodiode comparator input.
- arm, in, 1: single-cycle pulse that opens a measurement window.
- sensor_out, out, 1: debounced light level (1 = lit).
- sensor_trigger, out, 1: single-cycle pulse on the first qualifying rising edge in a window.
- timeout, out, 1: single-cycle pulse when a window expires without a trigger.
- armed, out, 1: high while a window is open (state WAIT_DARK or ARMED).
- edge_count, out, 16: count of all debounced rising edges; saturates at 16'hFFFF.

Behaviour:
- Reset (rstn low, asynchronous), all outputs and internal state cleared:
  - sync chain = 0; filtered level = 0; debounce counter = 0; timeout counter = 0.
  - state = IDLE; sensor_out = 0; sensor_trigger = 0; timeout = 0; armed = 0; edge_count = 0.
- Synchroniser:
  - `sensor` passes through SYNC_STAGES flops, then is XOR'd with ~ACTIVE_HIGH to give `s`.
- Debounce:
  - If `s` == level: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES-1: level ← `s`, counter ← 0.
  - Else: counter++.
  - Any single-cycle disagreement with the level restarts the count.
  - sensor_out = level (registered).
  - Raw-edge to sensor_out latency is exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Rising edge `rise`:
  - Asserted in the cycle the level register transitions 0→1.
  - Evaluated on the same edge that updates the level, so sensor_trigger and sensor_out rise together.
  - edge_count increments on every `rise` and holds at 16'hFFFF.
- State machine, one-hot or encoded at implementer's choice:
  - IDLE:
    - arm and level=1 → WAIT_DARK.
    - arm and level=0 → ARMED.
  - WAIT_DARK (screen already lit at arm; an edge must be preceded by dark):
    - level=0 → ARMED.
    - A `rise` in this state is impossible by construction.
  - ARMED:
    - `rise` → sensor_trigger=1 for one cycle, state → IDLE.
  - Timeout counter:
    - Cleared on every arm; increments each cycle in WAIT_DARK or ARMED.
    - On reaching TIMEOUT_CYCLES-1 without `rise`: timeout=1 for one cycle, state → IDLE.
  - armed = (state != IDLE), registered.
- Simultaneous events:
  - arm while WAIT_DARK/ARMED: the window restarts. The timeout counter clears and the state is re-chosen from the current level, as from IDLE.
  - arm in the same cycle as `rise`: arm wins. No trigger is issued and the window restarts.
  - `rise` in the same cycle as timeout expiry (ARMED): the trigger wins and timeout is not asserted.
  - sensor_trigger and timeout are never high in the same cycle.
- Outside a window:
  - `rise` in IDLE updates sensor_out and edge_count only; no trigger.
- Reset mid-window:
  - Immediate return to IDLE, outputs cleared.
  - A pending debounce is discarded.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, TIMEOUT_CYCLES=100, ACTIVE_HIGH=1):
1. Latency: sensor=0, pulse arm, wait 10 cycles, then drive sensor 0→1 at cycle T → sensor_out and sensor_trigger both rise at T+6; trigger is high exactly 1 cycle; armed falls the cycle after; edge_count=1.
2. Glitch rejection: arm, then drive sensor high for 3 cycles, low for 1, high for 3, low → sensor_out stays 0, no trigger, edge_count=0; timeout pulses 100 cycles after arm.
3. Lit at arm: hold sensor=1 until sensor_out=1, pulse arm → armed=1 and state WAIT_DARK. Drive sensor 0 for 8 cycles, then 1 → exactly one trigger, 6 cycles after the second rising edge.
4. Re-arm and priority:
   - arm at cycle 0, re-arm at cycle 90 → no timeout at cycle 100; timeout at cycle 190.
   - arm coincident with `rise` → no trigger.
   - `rise` coincident with the final timeout cycle → trigger only.
5. Reset and saturation:
   - Deassert rstn mid-ARMED → all outputs 0 asynchronously.
   - Force 65537 debounced edges → edge_count = 16'hFFFF.
6. ACTIVE_HIGH=0: drive sensor 1→0 → sensor_out rises after 6 cycles.
